regfile_2w_scoreboard: RTL

- Parametrised successor to the 16x32 structural register file.
- Provides 2^N registers of M bits, two combinational read ports and two write ports:
  - ALU write-back port (port 3).
  - Late-arriving load-return port (port L).
- Adds write-to-read bypass, a per-register pending-load scoreboard, and a hardwired PC-read slot at the top index.
- Sits between the decode stage (reads, hazard detection) and the write-back and memory stages in the CPU.

---
 rtl/regfile_2w_scoreboard_pkg.sv | 15 +
 rtl/regfile_2w_scoreboard_sb.sv | 54 +++++
 rtl/regfile_2w_scoreboard.sv | 104 ++++++++++
 3 files changed

// File: rtl/regfile_2w_scoreboard_pkg.sv
// Shared sizing, types and helpers for the two-write-port register file.
package regfile_pkg;

    parameter int unsigned N_DEF = 4;
    parameter int unsigned M_DEF = 32;

    typedef logic [N_DEF-1:0] addr_t;
    typedef logic [M_DEF-1:0] word_t;

    // Top index of a 2^n register file; reads there return the PC.
    function automatic int unsigned pc_idx(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

endpackage

// File: rtl/regfile_2w_scoreboard_sb.sv
// Pending-load scoreboard: one busy bit per register, set on load issue and
// cleared on load return, with a new issue beating a return to the same bit.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter bit          BYPASS = 1'b1,
    parameter int unsigned PC_IDX = pc_idx(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         busy_set,
    input  logic [N-1:0] busy_addr,
    input  logic         ld_valid,
    input  logic [N-1:0] ld_addr,
    input  logic [N-1:0] A1,
    input  logic [N-1:0] A2,
    output logic         busy1,
    output logic         busy2
);

    localparam int unsigned R = 2 ** N;

    logic [R-1:0] busy_q;
    logic [R-1:0] set_vec;
    logic [R-1:0] clr_vec;
    logic         clr1;
    logic         clr2;

    // One-hot decode of this cycle's set and clear requests.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (busy_set) set_vec[busy_addr] = 1'b1;
        if (ld_valid) clr_vec[ld_addr]   = 1'b1;
    end

    // Busy vector update; set is OR-ed in after clear so a fresh issue wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q         <= (busy_q & ~clr_vec) | set_vec;
            busy_q[PC_IDX] <= 1'b0;
        end
    end

    // A returning load is forwarded this cycle, so its bit already reads clear.
    assign clr1  = BYPASS && ld_valid && (ld_addr == A1);
    assign clr2  = BYPASS && ld_valid && (ld_addr == A2);
    assign busy1 = busy_q[A1] & ~clr1;
    assign busy2 = busy_q[A2] & ~clr2;

endmodule

// File: rtl/regfile_2w_scoreboard.sv
// 2^N x M register file with an ALU write-back port, a load-return port,
// write-to-read bypass, pending-load scoreboard and a hardwired PC slot.
module regfile_2w_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned N      = N_DEF,
    parameter int unsigned M      = M_DEF,
    parameter bit          BYPASS = 1'b1,
    parameter int unsigned PC_IDX = pc_idx(N)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         WE3,
    input  logic [N-1:0] A1,
    input  logic [N-1:0] A2,
    input  logic [N-1:0] A3,
    input  logic [M-1:0] WD3,
    input  logic         ld_valid,
    input  logic [N-1:0] ld_addr,
    input  logic [M-1:0] ld_data,
    input  logic         busy_set,
    input  logic [N-1:0] busy_addr,
    input  logic [M-1:0] pc_in,
    output logic [M-1:0] RD1,
    output logic [M-1:0] RD2,
    output logic         busy1,
    output logic         busy2,
    output logic         hazard
);

    localparam int unsigned   R    = 2 ** N;
    localparam logic [N-1:0]  PC_A = N'(PC_IDX);

    logic [R-1:0][M-1:0] regs;

    // Read mux: PC slot first, then ALU bypass, then load bypass, then array.
    function automatic logic [M-1:0] read_port(
        input logic [N-1:0]          a,
        input logic [R-1:0][M-1:0]   arr,
        input logic [M-1:0]          pc,
        input logic                  we,
        input logic [N-1:0]          wa,
        input logic [M-1:0]          wd,
        input logic                  lv,
        input logic [N-1:0]          la,
        input logic [M-1:0]          ld
    );
        if (a == PC_A)                 return pc;
        if (BYPASS && we && (wa == a)) return wd;
        if (BYPASS && lv && (la == a)) return ld;
        return arr[a];
    endfunction

    for (genvar i = 0; i < R; i++) begin : g_reg
        localparam logic [N-1:0] IDX = N'(i);
        if (i == PC_IDX) begin : g_pc
            // The PC belongs to fetch; no storage here, writes are dropped.
            assign regs[i] = '0;
        end else begin : g_rw
            logic [M-1:0] q;
            logic         we_alu;
            logic         we_ld;

            assign we_alu = WE3 && (A3 == IDX);
            assign we_ld  = ld_valid && (ld_addr == IDX);

            // Enabled register; the ALU result is newer so it beats a load.
            always_ff @(posedge clk) begin
                if (reset) begin
                    q <= '0;
                end else if (we_alu) begin
                    q <= WD3;
                end else if (we_ld) begin
                    q <= ld_data;
                end
            end

            assign regs[i] = q;
        end
    end

    assign RD1 = read_port(A1, regs, pc_in, WE3, A3, WD3, ld_valid, ld_addr, ld_data);
    assign RD2 = read_port(A2, regs, pc_in, WE3, A3, WD3, ld_valid, ld_addr, ld_data);

    regfile_scoreboard #(
        .N      (N),
        .BYPASS (BYPASS),
        .PC_IDX (PC_IDX)
    ) u_sb (
        .clk       (clk),
        .reset     (reset),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .A1        (A1),
        .A2        (A2),
        .busy1     (busy1),
        .busy2     (busy2)
    );

    assign hazard = busy1 | busy2;

endmodule
